// File: rtl/npc_arb_pkg.sv
// Shared definitions for the NPC memory arbiter.
//   - arb_state_e : arbiter FSM states (IDLE / REQ / RSP / FAULT)
//   - MID_IFU / MID_LSU : master ids carried in the 1-bit grant register
//   - ARB_ADDR_W / ARB_DATA_W : default bus widths
package npc_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RSP   = 2'd2,
    ST_FAULT = 2'd3
  } arb_state_e;

endpackage

// File: rtl/npc_arb_timeout.sv
// Response timeout counter for the NPC memory arbiter.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   clear        : zero the counter (start of a new response wait)
//   enable       : one more cycle waited without a slave response
//   expired      : the counter reaches TIMEOUT_CYC on this enabled cycle
// TIMEOUT_CYC = 0 disables the timeout (expired stays low).
// The counter saturates at its maximum value and never wraps.
module npc_arb_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enable && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || clear) cnt_q <= '0;
    else if (enable)    cnt_q <= cnt_d;
  end

  // Fire on the edge where the count lands on the limit, so the FSM leaves
  // RSP after exactly TIMEOUT_CYC silent cycles.
  generate
    if (TIMEOUT_CYC != 0) begin : g_timeout
      assign expired = enable && (cnt_d == CNT_LIMIT);
    end else begin : g_no_timeout
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/npc_mem_arbiter.sv
// Two-master arbiter for the single NPC memory port (IFU = m0, LSU = m1).
// One transaction outstanding at a time; a response timeout turns a dead
// slave into an error response.
// Ports:
//   clock, reset            : system clock, synchronous active-high reset
//   m0_* / m1_*             : master request (valid/ready + payload) and
//                             response (valid/ready + rdata/rsp_err)
//   s_*                     : slave request mirror and slave response
//   dbg_state               : current FSM state (arb_state_e encoding)
// Handshake rule (all channels): a transfer happens on a rising edge where
// valid && ready; the sender holds payload stable while valid && !ready, and
// valid is never withdrawn before the transfer.
// Build option: define ARB_ROUND_ROBIN_EN to break request ties in favour of
// the master not granted last; otherwise the LSU (m1) always wins a tie.
module npc_mem_arbiter
  import npc_arb_pkg::*;
#(
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_wen,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_rsp_valid,
  input  logic                m0_rsp_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rsp_err,
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_wen,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_rsp_valid,
  input  logic                m1_rsp_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rsp_err,
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_wen,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  input  logic                s_rsp_valid,
  output logic                s_rsp_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_rsp_err,
  output logic [1:0]          dbg_state
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       pick;
  logic       g_rsp_ready;
  logic       tmo_expired;

  // Arbitration decision used when leaving IDLE.
`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  always_ff @(posedge clock) begin
    if (reset) last_q <= MID_LSU;
    else if ((state_q == ST_IDLE) && (m0_req_valid || m1_req_valid)) last_q <= pick;
  end

  always_comb begin
    if (m0_req_valid && m1_req_valid) pick = ~last_q;
    else                              pick = m1_req_valid;
  end
`else
  always_comb pick = m1_req_valid ? MID_LSU : MID_IFU;
`endif

  assign g_rsp_ready = grant_q ? m1_rsp_ready : m0_rsp_ready;
  assign dbg_state   = state_q;

  npc_arb_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   ((state_q == ST_REQ) && s_req_ready),
    .enable  ((state_q == ST_RSP) && !s_rsp_valid),
    .expired (tmo_expired)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= MID_IFU;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req_valid || m1_req_valid) begin
          grant_d = pick;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (s_req_ready) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (s_rsp_valid && g_rsp_ready) state_d = ST_IDLE;
        else if (tmo_expired)           state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (g_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  logic              req_rdy;
  logic              rsp_v;
  logic              rsp_e;
  logic [DATA_W-1:0] rsp_d;

  always_comb begin
    s_req_valid = 1'b0;
    s_addr      = '0;
    s_wen       = 1'b0;
    s_wdata     = '0;
    s_wmask     = '0;
    s_rsp_ready = 1'b0;
    req_rdy     = 1'b0;
    rsp_v       = 1'b0;
    rsp_e       = 1'b0;
    rsp_d       = '0;
    case (state_q)
      ST_IDLE: begin
        s_rsp_ready = 1'b1;  // drain stray late responses
      end
      ST_REQ: begin
        s_req_valid = 1'b1;
        s_addr      = grant_q ? m1_addr  : m0_addr;
        s_wen       = grant_q ? m1_wen   : m0_wen;
        s_wdata     = grant_q ? m1_wdata : m0_wdata;
        s_wmask     = grant_q ? m1_wmask : m0_wmask;
        req_rdy     = s_req_ready;
      end
      ST_RSP: begin
        rsp_v       = s_rsp_valid;
        rsp_e       = s_rsp_err;
        rsp_d       = s_rsp_err ? '0 : s_rdata;
        s_rsp_ready = g_rsp_ready;
      end
      ST_FAULT: begin
        rsp_v       = 1'b1;
        rsp_e       = 1'b1;
        s_rsp_ready = 1'b1;  // discard anything the slave sends late
      end
      default: ;
    endcase
  end

  // Route the shared channels to the granted master only.
  always_comb begin
    m0_req_ready = req_rdy & (grant_q == MID_IFU);
    m1_req_ready = req_rdy & (grant_q == MID_LSU);
    m0_rsp_valid = rsp_v   & (grant_q == MID_IFU);
    m1_rsp_valid = rsp_v   & (grant_q == MID_LSU);
    m0_rsp_err   = rsp_e   & (grant_q == MID_IFU);
    m1_rsp_err   = rsp_e   & (grant_q == MID_LSU);
    m0_rdata     = (grant_q == MID_IFU) ? rsp_d : '0;
    m1_rdata     = (grant_q == MID_LSU) ? rsp_d : '0;
  end

endmodule
